// File: rtl/svc_err_monitor_pkg.sv
// svc_err_monitor_pkg: shared saturating-increment helper for the error monitor.
package svc_err_monitor_pkg;

    localparam int SAT_MAX_W = 32;

    // Callers zero-extend into SAT_MAX_W bits and pass their own all-ones value.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] v,
        input logic [SAT_MAX_W-1:0] ones,
        input logic                 inc
    );
        return (inc && v != ones) ? v + SAT_MAX_W'(1) : v;
    endfunction

endpackage

// File: rtl/svc_pulse_stretch.sv
// svc_pulse_stretch: retriggerable stretcher, out stays high STRETCH_CYCLES cycles after the last trig.
module svc_pulse_stretch #(
    parameter  int STRETCH_CYCLES = 1048576,
    localparam int STR_W          = $clog2(STRETCH_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic trig,
    output logic out
);

    logic [STR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr            ? '0 :
                trig           ? STR_W'(STRETCH_CYCLES) :
                (cnt_q != '0)  ? cnt_q - STR_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign out = (cnt_q != '0);

endmodule

// File: rtl/svc_err_monitor.sv
// svc_err_monitor: per-channel saturating error counters, per-frame snapshots,
// sticky/saturation flags and a stretched any-error LED.
module svc_err_monitor
    import svc_err_monitor_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int CNT_WIDTH      = 16,
    parameter  int STRETCH_CYCLES = 1048576,
    localparam int SEL_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    err_i,
    input  logic                 frame_sync,
    input  logic                 clr,
    input  logic [SEL_W-1:0]     ch_sel,
    output logic [CNT_WIDTH-1:0] total_cnt,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [NUM_CH-1:0]    sticky,
    output logic [NUM_CH-1:0]    sat,
    output logic                 led
);

    localparam logic [SAT_MAX_W-1:0] ONES = SAT_MAX_W'({CNT_WIDTH{1'b1}});

    function automatic logic [CNT_WIDTH-1:0] inc_c(input logic [CNT_WIDTH-1:0] v, input logic e);
        return CNT_WIDTH'(sat_inc(SAT_MAX_W'(v), ONES, e));
    endfunction

    logic                 sync_q;
    logic                 boundary;
    logic [CNT_WIDTH-1:0] total_v [NUM_CH];
    logic [CNT_WIDTH-1:0] snap_v  [NUM_CH];
    logic [CNT_WIDTH-1:0] tot_sel, snap_sel;
    logic [CNT_WIDTH-1:0] total_cnt_q, frame_cnt_q;

    // sync_q resets high so a level already high at release is not a boundary.
    assign boundary = frame_sync & ~sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 1'b1;
        else        sync_q <= frame_sync;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_WIDTH-1:0] total_q, total_d, run_q, run_d, snap_q;
        logic                 sticky_q, sat_q;

        assign total_d = inc_c(total_q, err_i[c]);
        assign run_d   = inc_c(run_q, err_i[c]);

        // An error on the boundary cycle is folded into the closing frame's snapshot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                total_q  <= '0;
                run_q    <= '0;
                snap_q   <= '0;
                sticky_q <= 1'b0;
                sat_q    <= 1'b0;
            end else if (clr) begin
                total_q  <= '0;
                run_q    <= '0;
                snap_q   <= '0;
                sticky_q <= 1'b0;
                sat_q    <= 1'b0;
            end else begin
                total_q  <= total_d;
                sat_q    <= &total_d;
                sticky_q <= sticky_q | err_i[c];
                run_q    <= boundary ? '0 : run_d;
                snap_q   <= boundary ? run_d : snap_q;
            end
        end

        assign total_v[c] = total_q;
        assign snap_v[c]  = snap_q;
        assign sticky[c]  = sticky_q;
        assign sat[c]     = sat_q;
    end

    // Selects beyond NUM_CH match no channel and read as zero.
    always_comb begin
        tot_sel  = '0;
        snap_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == SEL_W'(c)) begin
                tot_sel  = total_v[c];
                snap_sel = snap_v[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            total_cnt_q <= tot_sel;
            frame_cnt_q <= snap_sel;
        end
    end

    assign total_cnt = total_cnt_q;
    assign frame_cnt = frame_cnt_q;

    svc_pulse_stretch #(
        .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_led (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .trig (|err_i),
        .out  (led)
    );

endmodule
